ram_acc: RTL

- Parametrised single-port synchronous RAM, successor to the fixed 5-bit adder-fed RAM; generalised address and data widths.
- Adds an automatic zero-clear sweep after reset and a read-valid strobe.
- Adds an accumulate mode: read-modify-write `mem[addr] += din`, with wrap or saturation and an overflow flag.
- Used as a histogram/accumulator store behind datapath adders.

---
 rtl/ram_acc_if.sv | 26 ++
 rtl/ram_acc.sv | 129 ++++++++++++
 2 files changed

// File: rtl/ram_acc_if.sv
// Request/response bus for the ram_acc accumulator store.
// The master drives a request, and the slave returns registered data and the status strobes.
interface ram_acc_if #(
  parameter int AW = 4,
  parameter int DW = 5
);
  logic          cs;
  logic          we;
  logic          acc;
  logic [AW-1:0] addr;
  logic [DW-1:0] din;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          busy;
  logic          ovf;

  modport master (
    output cs, we, acc, addr, din,
    input  dout, dout_valid, busy, ovf
  );

  modport slave (
    input  cs, we, acc, addr, din,
    output dout, dout_valid, busy, ovf
  );
endinterface

// File: rtl/ram_acc.sv
// Single-port RAM that zero-clears itself after reset.
// It also supports a two-cycle read-modify-write accumulate that can wrap or saturate.
module ram_acc #(
  parameter int AW  = 4,
  parameter int DW  = 5,
  parameter int SAT = 0
) (
  input  logic      clk,
  input  logic      rst_n,
  ram_acc_if.slave  bus
);

  localparam int DEPTH = 1 << AW;

  localparam logic [1:0] ST_CLEAR = 2'd0;
  localparam logic [1:0] ST_IDLE  = 2'd1;
  localparam logic [1:0] ST_ACCWR = 2'd2;

  logic [DW-1:0] mem [DEPTH];

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] clrPtr_q, clrPtr_d;
  logic [AW-1:0] accAddr_q, accAddr_d;
  logic [DW-1:0] accDin_q, accDin_d;
  logic [DW-1:0] operand_q, operand_d;
  logic [DW-1:0] dout_q, dout_d;
  logic          doutValid_q, doutValid_d;
  logic          ovf_q, ovf_d;

  logic          memWe;
  logic [AW-1:0] memWaddr;
  logic [DW-1:0] memWdata;
  logic [DW:0]   accSum;
  logic [DW-1:0] accResult;

  // The sum is one bit wider than the data, so the carry is the overflow indication in both modes.
  assign accSum    = {1'b0, operand_q} + {1'b0, accDin_q};
  assign accResult = ((SAT != 0) && accSum[DW]) ? {DW{1'b1}} : accSum[DW-1:0];

  always_comb begin
    state_d     = state_q;
    clrPtr_d    = clrPtr_q;
    accAddr_d   = accAddr_q;
    accDin_d    = accDin_q;
    operand_d   = operand_q;
    dout_d      = dout_q;
    doutValid_d = 1'b0;
    ovf_d       = 1'b0;
    memWe       = 1'b0;
    memWaddr    = clrPtr_q;
    memWdata    = '0;

    case (state_q)
      ST_CLEAR: begin
        memWe    = 1'b1;
        clrPtr_d = clrPtr_q + AW'(1);
        if (clrPtr_q == {AW{1'b1}}) begin
          state_d  = ST_IDLE;
          clrPtr_d = '0;
        end
      end
      ST_IDLE: begin
        if (bus.cs) begin
          if (bus.acc) begin
            accAddr_d = bus.addr;
            accDin_d  = bus.din;
            operand_d = mem[bus.addr];
            state_d   = ST_ACCWR;
          end else if (bus.we) begin
            memWe    = 1'b1;
            memWaddr = bus.addr;
            memWdata = bus.din;
          end else begin
            dout_d      = mem[bus.addr];
            doutValid_d = 1'b1;
          end
        end
      end
      ST_ACCWR: begin
        memWe       = 1'b1;
        memWaddr    = accAddr_q;
        memWdata    = accResult;
        dout_d      = accResult;
        doutValid_d = 1'b1;
        ovf_d       = accSum[DW];
        state_d     = ST_IDLE;
      end
      default: begin
        state_d  = ST_CLEAR;
        clrPtr_d = '0;
      end
    endcase
  end

  // A reset aborts a pending accumulate, because the operand is never written back from CLEAR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_CLEAR;
      clrPtr_q    <= '0;
      accAddr_q   <= '0;
      accDin_q    <= '0;
      operand_q   <= '0;
      dout_q      <= '0;
      doutValid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      clrPtr_q    <= clrPtr_d;
      accAddr_q   <= accAddr_d;
      accDin_q    <= accDin_d;
      operand_q   <= operand_d;
      dout_q      <= dout_d;
      doutValid_q <= doutValid_d;
      ovf_q       <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (memWe) begin
      mem[memWaddr] <= memWdata;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = doutValid_q;
  assign bus.ovf        = ovf_q;
  assign bus.busy       = (state_q != ST_IDLE);

endmodule
